// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: fetches one instruction over a req/ack handshake,
// waits out decoder and execute latency, then writes back and advances the PC.
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          DEC_LAT       = 1,
    parameter int          EX_CYCLES     = 2,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] komut,
    input  logic [6:0]  opcode,
    input  logic        hata,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic        we,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;
    localparam logic [1:0] FC_MISALGN = 2'd3;

    // Each counter only needs to reach its own terminal value (N-1).
    localparam int FCW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [FCW-1:0] FT_LAST = FCW'(FETCH_TIMEOUT - 1);
    localparam logic [FCW-1:0] FC_ONE  = FCW'(1);
    localparam logic [1:0]     DL_LAST = 2'(DEC_LAT - 1);
    localparam logic [1:0]     DL_ONE  = 2'd1;
    localparam logic [3:0]     EX_LAST = 4'(EX_CYCLES - 1);
    localparam logic [3:0]     EX_ONE  = 4'd1;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_pc;
    logic [31:0]     r_komut;
    logic [31:0]     r_retired;
    logic [1:0]      r_fault_code;
    logic [6:0]      r_opcode;
    logic [FCW-1:0]  r_fcnt;
    logic [1:0]      r_dcnt;
    logic [3:0]      r_ecnt;

    logic            w_launch;
    logic            w_timeout;
    logic            w_illegal;
    logic            w_ecall;
    logic            w_retire;
    logic            w_misalign;
    logic            w_we;
    logic            w_ex_first;

    assign w_ex_first = (r_ecnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_timeout   = 1'b0;
        w_illegal   = 1'b0;
        w_ecall     = 1'b0;
        w_retire    = 1'b0;
        w_misalign  = 1'b0;
        w_we        = 1'b0;
        unique case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                // An ack in the expiring cycle still completes the fetch.
                if (imem_ack) begin
                    w_state_nxt = S_DECODE;
                end else if (r_fcnt == FT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                if (r_dcnt == DL_LAST) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_ex_first && hata) begin
                    w_illegal   = 1'b1;
                    w_state_nxt = S_FAULT;
                end else if (w_ex_first && (opcode == OP_ECALL)) begin
                    w_ecall     = 1'b1;
                    w_state_nxt = S_HALT;
                end else if (r_ecnt == EX_LAST) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                if (pc_load && (pc_target[1:0] != 2'b00)) begin
                    w_misalign  = 1'b1;
                    w_state_nxt = S_FAULT;
                end else begin
                    w_retire    = 1'b1;
                    w_we        = (r_opcode != OP_STORE) && (r_opcode != OP_BRANCH);
                    w_state_nxt = S_FETCH;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_komut      <= '0;
            r_retired    <= '0;
            r_fault_code <= '0;
            r_opcode     <= '0;
            r_fcnt       <= '0;
            r_dcnt       <= '0;
            r_ecnt       <= '0;
        end else begin
            if (w_launch) begin
                r_pc      <= RESET_PC;
                r_retired <= '0;
            end

            if (r_state == S_FETCH) begin
                if (imem_ack) begin
                    r_komut <= imem_data;
                end
                r_fcnt <= (w_state_nxt == S_FETCH) ? r_fcnt + FC_ONE : '0;
            end

            if (r_state == S_DECODE) begin
                r_dcnt <= (w_state_nxt == S_DECODE) ? r_dcnt + DL_ONE : '0;
            end

            // Opcode is latched on the first execute cycle so WB does not
            // depend on the decoder output staying valid.
            if (r_state == S_EXEC) begin
                if (w_ex_first) begin
                    r_opcode <= opcode;
                end
                r_ecnt <= (w_state_nxt == S_EXEC) ? r_ecnt + EX_ONE : '0;
            end

            if (w_ecall || w_retire) begin
                r_retired <= r_retired + 32'd1;
            end

            if (w_retire) begin
                r_pc <= pc_load ? pc_target : r_pc + 32'd4;
            end

            if (w_illegal) begin
                r_fault_code <= FC_ILLEGAL;
            end else if (w_timeout) begin
                r_fault_code <= FC_TIMEOUT;
            end else if (w_misalign) begin
                r_fault_code <= FC_MISALGN;
            end
        end
    end

    assign imem_req   = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign komut      = r_komut;
    assign we         = w_we;
    assign pc         = r_pc;
    assign busy       = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                        (r_state == S_EXEC)  || (r_state == S_WB);
    assign halted     = (r_state == S_HALT);
    assign fault      = (r_state == S_FAULT);
    assign fault_code = r_fault_code;
    assign retired    = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a memory/decoder model predicts fetch
// addresses, retire counts and write-enable pulses as instructions are acked.
module tb_cpu_sequencer;

    localparam logic [31:0] W_ADDI  = 32'h0000_0013;
    localparam logic [31:0] W_STORE = 32'h0000_2023;
    localparam logic [31:0] W_ECALL = 32'h0000_0073;
    localparam logic [31:0] W_ILL   = 32'hFFFF_FFFF;
    localparam logic [31:0] W_BR40  = 32'h0400_0063;
    localparam logic [31:0] W_BR42  = 32'h0420_0063;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_ECALL  = 7'b1110011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic [31:0] komut;
    logic [6:0]  opcode = '0;
    logic        hata = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_target = '0;
    logic        we;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] retired;

    cpu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .komut      (komut),
        .opcode     (opcode),
        .hata       (hata),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .we         (we),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault),
        .fault_code (fault_code),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ret;
    } fetch_exp_t;

    typedef struct {
        int   due;
        logic we;
    } we_exp_t;

    fetch_exp_t  q_addr[$];
    we_exp_t     q_we[$];
    logic [31:0] prog [0:31];
    logic [31:0] m_ret = '0;
    int          n_err = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    int          req_cnt = 0;
    logic        prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Predict the outcome of an instruction at the moment it is handed over.
    task automatic model_fetch(input logic [31:0] a, input logic [31:0] w);
        we_exp_t     e;
        fetch_exp_t  f;
        logic [31:0] tgt;
        e.due = cyc + 4;
        tgt   = {20'h0, w[31:20]};
        if (w == W_ILL) begin
            e.we = 1'b0;
        end else if (w[6:0] == OP_ECALL) begin
            m_ret = m_ret + 32'd1;
        end else if (w[6:0] == OP_BRANCH) begin
            e.we = 1'b0;
            q_we.push_back(e);
            if (tgt[1:0] == 2'b00) begin
                m_ret  = m_ret + 32'd1;
                f.addr = tgt;
                f.ret  = m_ret;
                q_addr.push_back(f);
            end
        end else begin
            m_ret  = m_ret + 32'd1;
            e.we   = (w[6:0] != OP_STORE);
            q_we.push_back(e);
            f.addr = a + 32'd4;
            f.ret  = m_ret;
            q_addr.push_back(f);
        end
    endtask

    // Memory responder, decoder model and output monitor, all on the falling edge.
    initial begin
        we_exp_t    e;
        fetch_exp_t f;
        forever begin
            @(negedge clk);
            opcode    = komut[6:0];
            hata      = (komut == W_ILL);
            pc_load   = (komut[6:0] == OP_BRANCH);
            pc_target = {20'h0, komut[31:20]};
            if (!reset) begin
                prev_req = 1'b0;
                req_cnt  = 0;
                imem_ack = 1'b0;
            end else begin
                if (q_we.size() != 0 && q_we[0].due == cyc) begin
                    e = q_we.pop_front();
                    chk("we", 32'(we), 32'(e.we));
                end else if (we) begin
                    chk("we_spurious", 32'(we), 32'd0);
                end
                if (imem_req && !prev_req) begin
                    if (q_addr.size() == 0) begin
                        chk("fetch_unexpected", 32'(imem_req), 32'd0);
                    end else begin
                        f = q_addr.pop_front();
                        chk("imem_addr", imem_addr, f.addr);
                        chk("retired_at_fetch", retired, f.ret);
                    end
                end
                prev_req = imem_req;
                if (imem_req && ack_en && req_cnt == ack_delay) begin
                    imem_ack  = 1'b1;
                    imem_data = prog[imem_addr[6:2]];
                    model_fetch(imem_addr, imem_data);
                end else begin
                    imem_ack = 1'b0;
                end
                req_cnt = imem_req ? req_cnt + 1 : 0;
            end
        end
    end

    task automatic load_prog();
        for (int i = 0; i < 32; i++) prog[i] = W_ADDI;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        q_addr.delete();
        q_we.delete();
        m_ret = '0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input bit expect_launch);
        fetch_exp_t f;
        @(negedge clk);
        start = 1'b1;
        if (expect_launch) begin
            m_ret  = '0;
            f.addr = 32'h0;
            f.ret  = 32'h0;
            q_addr.push_back(f);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input string tag, input bit want_fault, input int maxc, output int n);
        n = 0;
        while (!(want_fault ? fault : halted) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(want_fault ? fault : halted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        load_prog();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_flags", {29'd0, halted, fault, we}, 32'd0);
        chk("rst_fcode", 32'(fault_code), 32'd0);
        chk("rst_komut", komut, 32'd0);

        // Straight-line addi run ending in ecall, then restart from HALT
        prog[3] = W_ECALL;
        pulse_start(1'b1);
        wait_state("halt_run1", 1'b0, 100, n);
        chk("halt_pc", pc, 32'hC);
        chk("halt_retired", retired, 32'd4);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_req", 32'(imem_req), 32'd0);
        pulse_start(1'b1);
        wait_state("halt_run2", 1'b0, 100, n);
        chk("restart_retired", retired, 32'd4);
        chk("run_queues_empty", 32'(q_addr.size() + q_we.size()), 32'd0);

        // Store then taken branch to 0x40
        do_reset();
        load_prog();
        prog[0]  = W_STORE;
        prog[1]  = W_BR40;
        prog[16] = W_ECALL;
        pulse_start(1'b1);
        wait_state("halt_branch", 1'b0, 100, n);
        chk("branch_pc", pc, 32'h40);
        chk("branch_retired", retired, 32'd3);

        // Illegal instruction on the second fetch
        do_reset();
        load_prog();
        prog[1] = W_ILL;
        pulse_start(1'b1);
        wait_state("fault_illegal", 1'b1, 100, n);
        chk("illegal_code", 32'(fault_code), 32'd1);
        chk("illegal_retired", retired, 32'd1);
        chk("illegal_pc", pc, 32'h4);
        pulse_start(1'b0);
        repeat (10) @(negedge clk);
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_sticky_busy", 32'(busy), 32'd0);
        chk("fault_sticky_code", 32'(fault_code), 32'd1);
        chk("fault_sticky_retired", retired, 32'd1);

        // Misaligned branch target
        do_reset();
        load_prog();
        prog[0] = W_BR42;
        pulse_start(1'b1);
        wait_state("fault_misalign", 1'b1, 100, n);
        chk("misalign_code", 32'(fault_code), 32'd3);
        chk("misalign_retired", retired, 32'd0);
        chk("misalign_pc", pc, 32'h0);

        // Fetch timeout: no ack at all
        do_reset();
        load_prog();
        ack_en = 1'b0;
        pulse_start(1'b1);
        wait_state("fault_timeout", 1'b1, 40, n);
        chk("timeout_cycles", 32'(n), 32'd16);
        chk("timeout_code", 32'(fault_code), 32'd2);
        chk("timeout_req", 32'(imem_req), 32'd0);
        ack_en = 1'b1;

        // Ack on the last allowed fetch cycle still completes
        do_reset();
        load_prog();
        prog[1]   = W_ECALL;
        ack_delay = 15;
        pulse_start(1'b1);
        wait_state("halt_late_ack", 1'b0, 200, n);
        chk("late_ack_fault", 32'(fault), 32'd0);
        chk("late_ack_retired", retired, 32'd2);
        chk("late_ack_pc", pc, 32'h4);
        ack_delay = 0;

        // Asynchronous reset in the middle of a fetch
        do_reset();
        load_prog();
        ack_en = 1'b0;
        pulse_start(1'b1);
        @(posedge clk);
        #2;
        chk("midfetch_req_pre", 32'(imem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("midfetch_req", 32'(imem_req), 32'd0);
        chk("midfetch_busy", 32'(busy), 32'd0);
        chk("midfetch_pc", pc, 32'h0);
        @(negedge clk);
        q_addr.delete();
        q_we.delete();
        m_ret  = '0;
        ack_en = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {30'd0, busy, imem_req}, 32'd0);
        chk("post_reset_flags", {30'd0, halted, fault}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
